// File: rtl/cpu_slave_responder.sv
// ============================================================================
// cpu_slave_responder
//
// Target side of the 68030-style asynchronous bus handshake. The host strobes
// (AS, DS, CS) are brought into the CLK domain through two-flop synchronisers.
// An access is decoded into a one-cycle register read or write strobe with
// byte-lane enables. Wait states are inserted, and the cycle is then
// terminated with a 32-bit DSACK, or with BERR when the optional timeout is
// built.
//
// Optional feature macro: CPU_RESP_BERR_TIMEOUT_EN
//   defined   : timeout counter and BERR state are built; TIMEOUT is honoured
//   undefined : no timeout logic, BERR tied low, WAIT holds until REG_RDY
//               is high or the address strobe goes away
//
// Parameters:
//   WAIT_CYCLES  minimum extra wait cycles before DSACK (0..15)
//   TIMEOUT      cycles from DECODE entry before BERR (2..255)
//
// Ports:
//   CLK, nRESET      system clock, asynchronous active-low reset
//   AS, DS, CS       asynchronous address strobe, data strobe, chip select
//   RW, SIZ, ADDR    access direction, transfer size, byte address
//   REG_RDY          register file ready
//   REG_ADDR         latched ADDR[7:2]
//   BYTE_EN          active byte lanes, bit 3 = D31:24 (offset 0)
//   REG_RD, REG_WR   one-cycle register read / write strobes
//   DOE              data output enable during reads
//   DSACK0, DSACK1   cycle termination (both asserted: 32-bit port)
//   BERR             bus error termination
// ============================================================================
module cpu_slave_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       AS,
    input  logic       DS,
    input  logic       CS,
    input  logic       RW,
    input  logic [1:0] SIZ,
    input  logic [7:0] ADDR,
    input  logic       REG_RDY,
    output logic [5:0] REG_ADDR,
    output logic [3:0] BYTE_EN,
    output logic       REG_RD,
    output logic       REG_WR,
    output logic       DOE,
    output logic       DSACK0,
    output logic       DSACK1,
    output logic       BERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_STROBE,
        S_WAIT,
        S_ACK,
        S_BERR
    } state_t;

    state_t     state;
    logic       as_meta, as_s;
    logic       ds_meta, ds_s;
    logic       cs_meta, cs_s;
    logic       rw_latched;
    logic [5:0] reg_addr;
    logic [3:0] byte_en;
    logic [3:0] wait_cnt;

    // Lanes run from the offset up to the end of the transfer, clipped at the
    // end of the 32-bit port. Lane offset k maps to bit 3-k.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                             input logic [1:0] ofs);
        logic [2:0] len;
        logic [2:0] last;
        len  = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        last = {1'b0, ofs} + len;
        if (last > 3'd4) begin
            last = 3'd4;
        end
        return (4'hF >> ofs) & ~(4'hF >> last);
    endfunction

    // Two-flop synchronisers for the asynchronous host strobes.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            as_meta <= 1'b0;
            as_s    <= 1'b0;
            ds_meta <= 1'b0;
            ds_s    <= 1'b0;
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
        end else begin
            as_meta <= AS;
            as_s    <= as_meta;
            ds_meta <= DS;
            ds_s    <= ds_meta;
            cs_meta <= CS;
            cs_s    <= cs_meta;
        end
    end

`ifdef CPU_RESP_BERR_TIMEOUT_EN
    logic [7:0] timeout_cnt;
    logic       timed_out;

    assign timed_out = (timeout_cnt >= TIMEOUT[7:0]);

    // Counts every cycle the access is in flight before termination,
    // saturating so a very long stall can never wrap back below TIMEOUT.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            timeout_cnt <= 8'd0;
        end else if (state == S_IDLE) begin
            timeout_cnt <= 8'd0;
        end else if ((state == S_DECODE || state == S_STROBE || state == S_WAIT)
                     && timeout_cnt != 8'hFF) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Handshake state machine. A dropped address strobe always takes
    // priority and returns to IDLE. In WAIT a ready register file beats a
    // simultaneous timeout.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_IDLE;
            rw_latched <= 1'b0;
            reg_addr   <= 6'd0;
            byte_en    <= 4'd0;
            wait_cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (as_s && cs_s) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    reg_addr   <= ADDR[7:2];
                    rw_latched <= RW;
                    byte_en    <= lane_mask(SIZ, ADDR[1:0]);
                    if (!as_s) begin
                        state <= S_IDLE;
                    end else if (ds_s) begin
                        state <= S_STROBE;
`ifdef CPU_RESP_BERR_TIMEOUT_EN
                    end else if (timed_out) begin
                        state <= S_BERR;
`endif
                    end
                end
                S_STROBE: begin
                    if (!as_s) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= WAIT_CYCLES[3:0];
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!as_s) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0 && REG_RDY) begin
                        state <= S_ACK;
`ifdef CPU_RESP_BERR_TIMEOUT_EN
                    end else if (timed_out) begin
                        state <= S_BERR;
`endif
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK, S_BERR: begin
                    if (!as_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register and the access latches.
    assign REG_ADDR = reg_addr;
    assign BYTE_EN  = byte_en;
    assign REG_RD   = (state == S_STROBE) && rw_latched;
    assign REG_WR   = (state == S_STROBE) && !rw_latched;
    assign DOE      = rw_latched &&
                      (state == S_STROBE || state == S_WAIT || state == S_ACK);
    assign DSACK0   = (state == S_ACK);
    assign DSACK1   = (state == S_ACK);
`ifdef CPU_RESP_BERR_TIMEOUT_EN
    assign BERR     = (state == S_BERR);
`else
    assign BERR     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_slave_responder.sv
// ============================================================================
// tb_cpu_slave_responder
//
// Directed bench for cpu_slave_responder with default parameters. Each
// access is described by its bus attributes and by the relative edges on
// which DS and REG_RDY arrive and AS is removed. The expected per-cycle
// outputs are derived from the handshake timing rules and stored in arrays
// indexed by cycle. A single compare process checks every cycle against
// those arrays. Literal pin checks inside the accesses anchor the timing
// rules. The timeout expectation follows CPU_RESP_BERR_TIMEOUT_EN.
// ============================================================================
module tb_cpu_slave_responder;

    localparam int WAIT_CYCLES = 1;
    localparam int TIMEOUT     = 64;
    localparam int N_CYC       = 512;
    localparam int NEVER       = 100000;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       AS, DS, CS, RW, REG_RDY;
    logic [1:0] SIZ;
    logic [7:0] ADDR;
    logic [5:0] REG_ADDR;
    logic [3:0] BYTE_EN;
    logic       REG_RD, REG_WR, DOE, DSACK0, DSACK1, BERR;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       checking = 1'b0;

    logic       exp_rd   [N_CYC];
    logic       exp_wr   [N_CYC];
    logic       exp_doe  [N_CYC];
    logic       exp_ack  [N_CYC];
    logic       exp_berr [N_CYC];
    logic       chk_lat  [N_CYC];
    logic [5:0] exp_addr [N_CYC];
    logic [3:0] exp_be   [N_CYC];

    cpu_slave_responder #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .AS      (AS),
        .DS      (DS),
        .CS      (CS),
        .RW      (RW),
        .SIZ     (SIZ),
        .ADDR    (ADDR),
        .REG_RDY (REG_RDY),
        .REG_ADDR(REG_ADDR),
        .BYTE_EN (BYTE_EN),
        .REG_RD  (REG_RD),
        .REG_WR  (REG_WR),
        .DOE     (DOE),
        .DSACK0  (DSACK0),
        .DSACK1  (DSACK1),
        .BERR    (BERR)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    // Cycle index: the number of rising edges seen so far.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Byte lanes from the size/offset rule: offsets o .. min(o+n,4)-1,
    // with lane offset k shown on bit 3-k.
    function automatic logic [3:0] modelLanes(input logic [1:0] siz,
                                              input logic [1:0] ofs);
        int n;
        logic [3:0] be;
        n  = (siz == 2'b00) ? 4 : int'(siz);
        be = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(ofs) && k < int'(ofs) + n) be[3-k] = 1'b1;
        end
        return be;
    endfunction

    // Compare process: one sample per cycle, 1 time unit after the edge.
    always @(posedge CLK) begin
        #1;
        if (checking && cyc < N_CYC) begin
            checkOutput("REG_RD",  REG_RD,  exp_rd[cyc]);
            checkOutput("REG_WR",  REG_WR,  exp_wr[cyc]);
            checkOutput("DOE",     DOE,     exp_doe[cyc]);
            checkOutput("DSACK0",  DSACK0,  exp_ack[cyc]);
            checkOutput("DSACK1",  DSACK1,  exp_ack[cyc]);
            checkOutput("BERR",    BERR,    exp_berr[cyc]);
            if (chk_lat[cyc]) begin
                checkOutput("REG_ADDR", REG_ADDR, exp_addr[cyc]);
                checkOutput("BYTE_EN",  BYTE_EN,  exp_be[cyc]);
            end
        end
    end

    // One bus access, called on a falling edge. Relative edge 0 is the first
    // rising edge that samples AS high. DS is sampled high from edge d_edge
    // and REG_RDY from edge r_edge. AS is removed at abort_f if that is
    // >= 0, otherwise `hold` edges after termination. A reset pulse is
    // applied just before edge rst_at if that is >= 0. `pin` selects the
    // literal spot checks for a given scenario.
    task automatic applyStimulus(input logic rw, input logic [1:0] siz,
                                 input logic [7:0] addr, input int d_edge,
                                 input int r_edge, input int hold,
                                 input int abort_f, input int rst_at,
                                 input int pin);
        int e, s, a, b, f, term, end_c;
        e = cyc + 1;
        s = (d_edge + 2 > 3) ? d_edge + 2 : 3;
        a = (s + 2 + WAIT_CYCLES > r_edge) ? s + 2 + WAIT_CYCLES : r_edge;
`ifdef CPU_RESP_BERR_TIMEOUT_EN
        b = TIMEOUT + 3;
`else
        b = NEVER;
`endif
        term = (b < a) ? b : a;
        if (rst_at >= 0)       f = rst_at;
        else if (abort_f >= 0) f = abort_f;
        else                   f = term + hold;
        end_c = (rst_at >= 0) ? rst_at - 1 : f + 1;

        for (int c = s; c <= end_c; c++) begin
            if (e + c < N_CYC) begin
                exp_doe[e+c]  = rw;
                chk_lat[e+c]  = 1'b1;
                exp_addr[e+c] = addr[7:2];
                exp_be[e+c]   = modelLanes(siz, addr[1:0]);
                if (c == s) begin
                    exp_rd[e+c] = rw;
                    exp_wr[e+c] = !rw;
                end
                if (a <= b && c >= a) exp_ack[e+c]  = 1'b1;
                if (b < a && c >= b)  exp_berr[e+c] = 1'b1;
            end
        end

        RW   = rw;
        SIZ  = siz;
        ADDR = addr;
        for (int k = 0; k <= f + 3; k++) begin
            AS      = (k < f);
            CS      = (k < f);
            DS      = (k >= d_edge) && (k < f);
            REG_RDY = (k >= r_edge);
            if (k == rst_at) begin
                nRESET = 1'b0;
                #1;
                checkOutput("rst DSACK0",   DSACK0,   1'b0);
                checkOutput("rst DSACK1",   DSACK1,   1'b0);
                checkOutput("rst BERR",     BERR,     1'b0);
                checkOutput("rst DOE",      DOE,      1'b0);
                checkOutput("rst REG_RD",   REG_RD,   1'b0);
                checkOutput("rst REG_ADDR", REG_ADDR, 6'd0);
                checkOutput("rst BYTE_EN",  BYTE_EN,  4'd0);
            end
            if (rst_at >= 0 && k == rst_at + 1) nRESET = 1'b1;
            // Literal spot checks; on the falling edge before edge k the
            // outputs show the result of edge k-1.
            case (pin)
                1: begin
                    if (k == 4)  checkOutput("p1 rd after e3", REG_RD, 1'b1);
                    if (k == 5)  checkOutput("p1 rd after e4", REG_RD, 1'b0);
                    if (k == 6)  checkOutput("p1 ack after e5", DSACK0, 1'b0);
                    if (k == 7) begin
                        checkOutput("p1 ack0 after e6", DSACK0, 1'b1);
                        checkOutput("p1 ack1 after e6", DSACK1, 1'b1);
                        checkOutput("p1 addr", REG_ADDR, 6'h04);
                        checkOutput("p1 be", BYTE_EN, 4'b1111);
                        checkOutput("p1 doe", DOE, 1'b1);
                    end
                    if (k == 10) checkOutput("p1 ack after e9", DSACK1, 1'b1);
                    if (k == 11) checkOutput("p1 ack after e10", DSACK0, 1'b0);
                end
                2: begin
                    if (k == 6) checkOutput("p2 wr after e5", REG_WR, 1'b0);
                    if (k == 7) begin
                        checkOutput("p2 wr after e6", REG_WR, 1'b1);
                        checkOutput("p2 be", BYTE_EN, 4'b0001);
                        checkOutput("p2 addr", REG_ADDR, 6'h08);
                        checkOutput("p2 doe", DOE, 1'b0);
                    end
                    if (k == 8) checkOutput("p2 wr after e7", REG_WR, 1'b0);
                end
                3: begin
                    if (k == 10) checkOutput("p3 ack after e9", DSACK0, 1'b0);
                    if (k == 11) begin
                        checkOutput("p3 ack after e10", DSACK0, 1'b1);
                        checkOutput("p3 be", BYTE_EN, 4'b0110);
                    end
                end
                4: begin
`ifdef CPU_RESP_BERR_TIMEOUT_EN
                    if (k == 67) checkOutput("p4 berr after e66", BERR, 1'b0);
                    if (k == 68) begin
                        checkOutput("p4 berr after e67", BERR, 1'b1);
                        checkOutput("p4 no ack", DSACK0, 1'b0);
                    end
`else
                    if (k == 100) checkOutput("p4 ack after e99", DSACK0, 1'b0);
                    if (k == 101) begin
                        checkOutput("p4 ack after e100", DSACK0, 1'b1);
                        checkOutput("p4 no berr", BERR, 1'b0);
                    end
`endif
                end
                5: begin
                    if (k == 10) checkOutput("p5 doe after e9", DOE, 1'b1);
                    if (k == 11) begin
                        checkOutput("p5 doe after e10", DOE, 1'b0);
                        checkOutput("p5 no ack", DSACK0, 1'b0);
                    end
                end
                default: ;
            endcase
            @(negedge CLK);
        end
        REG_RDY = 1'b1;
    endtask

    // Main stimulus sequence.
    initial begin
        for (int i = 0; i < N_CYC; i++) begin
            exp_rd[i]   = 1'b0;
            exp_wr[i]   = 1'b0;
            exp_doe[i]  = 1'b0;
            exp_ack[i]  = 1'b0;
            exp_berr[i] = 1'b0;
            chk_lat[i]  = 1'b0;
            exp_addr[i] = 6'd0;
            exp_be[i]   = 4'd0;
        end
        nRESET  = 1'b0;
        AS      = 1'b0;
        DS      = 1'b0;
        CS      = 1'b0;
        RW      = 1'b0;
        SIZ     = 2'b00;
        ADDR    = 8'h00;
        REG_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset DSACK0",   DSACK0,   1'b0);
        checkOutput("reset BERR",     BERR,     1'b0);
        checkOutput("reset REG_ADDR", REG_ADDR, 6'd0);
        checkOutput("reset BYTE_EN",  BYTE_EN,  4'd0);
        nRESET   = 1'b1;
        checking = 1'b1;
        @(negedge CLK);

        $display("[TB] long read @0x10");
        applyStimulus(1'b1, 2'b00, 8'h10, 0, 0, 2, -1, -1, 1);
        $display("[TB] byte write @0x23, late DS");
        applyStimulus(1'b0, 2'b01, 8'h23, 4, 0, 2, -1, -1, 2);
        $display("[TB] word read @0x01, REG_RDY late");
        applyStimulus(1'b1, 2'b10, 8'h01, 0, 10, 2, -1, -1, 3);
        $display("[TB] long read @0x40, REG_RDY very late");
        applyStimulus(1'b1, 2'b00, 8'h40, 0, 100, 3, -1, -1, 4);
        $display("[TB] AS dropped in WAIT");
        applyStimulus(1'b1, 2'b00, 8'h08, 0, 30, 2, 8, -1, 5);
        $display("[TB] three-byte write @0x14 after abort");
        applyStimulus(1'b0, 2'b11, 8'h14, 1, 0, 2, -1, -1, 0);
        $display("[TB] long read @0x32");
        applyStimulus(1'b1, 2'b00, 8'h32, 0, 0, 3, -1, -1, 0);
        $display("[TB] reset pulsed during ACK");
        applyStimulus(1'b1, 2'b10, 8'h0C, 0, 0, 2, -1, 8, 0);
        $display("[TB] word write @0x3E after reset");
        applyStimulus(1'b0, 2'b10, 8'h3E, 0, 0, 2, -1, -1, 0);

        repeat (4) @(negedge CLK);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_slave_responder.md
# cpu_slave_responder

Bus-slave responder for the 68030-style asynchronous bus: the target side of the same handshake that the DMA master state machine drives as initiator. Synchronises the host's address/data strobes, decodes the access into one-cycle register read/write strobes with byte-lane enables, inserts wait states, and terminates the cycle with 32-bit DSACK or, on timeout, BERR. Sits between the host bus pins and the register file.

## Interface
- WAIT_CYCLES, 1, minimum extra wait cycles before DSACK (0–15)
- TIMEOUT, 64, cycles from DECODE entry before BERR (2–255)
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- AS  in  1  address strobe, positive sense, asynchronous
- DS  in  1  data strobe, positive sense, asynchronous
- CS  in  1  decoded chip select, asynchronous
- RW  in  1  1 = read, 0 = write; stable while AS high
- SIZ  in  2  transfer size: 01 byte, 10 word, 11 three-byte, 00 long
- ADDR  in  8  byte address
- REG_RDY  in  1  register file ready; tie 1 if always ready
- REG_ADDR  out  6  latched ADDR[7:2]
- BYTE_EN  out  4  active lanes, bit 3 = D31:24 (offset 0)
- REG_RD  out  1  one-cycle read strobe
- REG_WR  out  1  one-cycle write strobe
- DOE  out  1  data output enable for reads
- DSACK0, DSACK1  out  1 each  cycle termination, both asserted (32-bit port)
- BERR  out  1  bus error

## Operation
- Reset: state IDLE, counters 0; all outputs 0.
- AS, DS, CS each pass a two-flop synchroniser (AS_s, DS_s, CS_s). RW, SIZ, ADDR sampled directly in DECODE.
- Outputs decoded from registered state/latches (Moore).
- IDLE: AS_s & CS_s -> DECODE; timeout counter cleared.
- DECODE: latch REG_ADDR, RW, BYTE_EN. DS_s -> STROBE, else stay.
- STROBE: REG_RD (read) or REG_WR (write) high for exactly this cycle; wait counter loaded with WAIT_CYCLES -> WAIT.
- WAIT: cnt != 0 -> decrement; cnt == 0 & REG_RDY -> ACK.
- ACK: DSACK0 = DSACK1 = 1 until AS_s low -> IDLE.
- BERR state: BERR = 1 until AS_s low -> IDLE.
- DOE = 1 in STROBE, WAIT, ACK when latched RW = 1.
- BYTE_EN: offset o = ADDR[1:0], size n (long = 4); lanes o .. min(o+n,4)-1 set. Examples: long@0 -> 1111, word@1 -> 0110, byte@3 -> 0001, three-byte@2 -> 0011, long@2 -> 0011.
- Boundaries:
  - AS_s drops in DECODE/STROBE/WAIT: abort -> IDLE, no DSACK/BERR; an issued strobe is not retracted.
  - REG_RDY and timeout in the same cycle: ACK wins.
  - AS_s drop and REG_RDY in the same cycle: IDLE wins.
  - CS sampled only in IDLE; later changes ignored.
  - Reset mid-cycle: immediate return to IDLE, all outputs 0.

## Timing
- Edge 0 = first CLK edge sampling AS high, with DS high and REG_RDY = 1.
- AS_s is high after edge 1, DECODE after edge 2, STROBE after edge 3, WAIT after edge 4.
- DSACK is asserted after edge 5 + WAIT_CYCLES, i.e. edge 6 at the default.
- DSACK/BERR negate one edge after the edge on which AS_s is seen low, i.e. 3 edges after AS falls.
- Timeout counter increments every cycle in DECODE/STROBE/WAIT (8-bit, saturating). Reaching TIMEOUT -> BERR state on the next edge.
- Back-to-back cycles need AS low for ≥ 2 CLK edges so AS_s returns low.

## Configuration
- CPU_RESP_BERR_TIMEOUT_EN defined: timeout counter and BERR state built; the TIMEOUT parameter is honoured.
- Not defined: no timeout logic; BERR tied 0; WAIT holds indefinitely until REG_RDY or AS_s drops.

## Test plan
- Long read @0x10, DS with AS, REG_RDY = 1, WAIT_CYCLES = 1 -> REG_ADDR = 0x04, BYTE_EN = 1111, REG_RD single pulse, DOE high, DSACK0/1 after edge 6, negated 3 edges after AS falls.
- Byte write @0x23, DS 4 cycles after AS -> REG_WR pulse only after DS_s, BYTE_EN = 0001, REG_ADDR = 0x08, DOE = 0.
- Word read @0x01 with REG_RDY held low 10 cycles -> BYTE_EN = 0110, DSACK 1 edge after REG_RDY rises.
- REG_RDY held low, TIMEOUT = 64, macro defined -> BERR asserted, no DSACK; with macro undefined -> no BERR, DSACK after REG_RDY.
- AS dropped in WAIT -> IDLE, no DSACK; the next access completes normally.
- nRESET pulsed during ACK -> DSACK/BERR/strobes 0 immediately; state IDLE.
